// File: rtl/pipeline_ctrl_if.sv
// Pipeline control bundle: stall/branch/exception requests in, stall/flush/redirect out.
// Request semantics: every request is a level, not a pulse. The requester keeps it
// asserted until the condition clears (a deferred branch keeps branch_flag high until
// the redirect is taken). No acknowledge is returned; stall/flush/pc_redirect act in
// the same cycle they are asserted. The master side is the pipeline and the slave
// side is the controller.
interface pipeline_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
);
   logic              stall_req_id;
   logic              stall_req_ex;
   logic              stall_req_mem;
   logic              branch_flag;
   logic [ADDR_W-1:0] branch_addr;
   logic              exception_flag;
   logic [4:0]        stall;
   logic [4:0]        flush;
   logic              pc_redirect;
   logic [ADDR_W-1:0] pc_redirect_addr;
   logic [1:0]        ctrl_state;
   logic [CNT_W-1:0]  stall_cycles;
   logic              stall_timeout;

   modport master (
      output stall_req_id, stall_req_ex, stall_req_mem,
      output branch_flag, branch_addr, exception_flag,
      input  stall, flush, pc_redirect, pc_redirect_addr,
      input  ctrl_state, stall_cycles, stall_timeout
   );

   modport slave (
      input  stall_req_id, stall_req_ex, stall_req_mem,
      input  branch_flag, branch_addr, exception_flag,
      output stall, flush, pc_redirect, pc_redirect_addr,
      output ctrl_state, stall_cycles, stall_timeout
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Bit i of stall/flush refers to: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB.
// stall/flush/redirect are combinational so a hazard holds the pipe in the
// cycle it is raised; state and counters are registered. ctrl_state exposes the FSM.
module pipeline_ctrl #(
   parameter bit          BRANCH_DELAY_SLOT = 1'b1,
   parameter logic [31:0] EXC_VECTOR        = 32'h0000_0380,
   parameter int          STALL_CNT_W       = 16,
   parameter int          STALL_TIMEOUT     = 1024
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_RUN    = 2'b00,
      S_STALL  = 2'b01,
      S_FREEZE = 2'b10,
      S_FLUSH  = 2'b11
   } state_t;

   localparam int TO_W = $clog2(STALL_TIMEOUT + 1);

   state_t                 r_state;
   logic [STALL_CNT_W-1:0] r_stall_cycles;
   logic [TO_W-1:0]        r_consec;
   logic                   r_timeout;

   state_t      w_next;
   logic [4:0]  w_stall;
   logic [4:0]  w_flush;
   logic        w_redirect;
   logic [31:0] w_redirect_addr;
   logic        w_any_req;

   // Next state and combinational stall/flush/redirect; reset forces everything idle
   // so a reset landing in FREEZE never lets the exception redirect escape.
   always_comb begin
      w_next          = r_state;
      w_stall         = '0;
      w_flush         = '0;
      w_redirect      = 1'b0;
      w_redirect_addr = '0;
      w_any_req       = bus.stall_req_id | bus.stall_req_ex | bus.stall_req_mem;
      case (r_state)
         S_RUN, S_STALL: begin
            if (bus.exception_flag) begin
               // Cycle N of an exception: freeze everything so MEM state is preserved.
               w_stall = 5'b11111;
               w_next  = S_FREEZE;
            end else begin
               if (bus.stall_req_mem)     w_stall = 5'b01111;
               else if (bus.stall_req_ex) w_stall = 5'b00111;
               else if (bus.stall_req_id) w_stall = 5'b00011;
               // A held register followed by a moving one: the moving one takes a bubble.
               w_flush[4:1] = w_stall[3:0] & ~w_stall[4:1];
               // A branch in a held ID stage waits; it fires on the first free cycle.
               if (bus.branch_flag && !w_stall[1]) begin
                  w_redirect      = 1'b1;
                  w_redirect_addr = bus.branch_addr;
                  if (!BRANCH_DELAY_SLOT) w_flush[1] = 1'b1;
               end
               w_next = w_any_req ? S_STALL : S_RUN;
            end
         end
         S_FREEZE: begin
            w_flush         = 5'b11110;
            w_redirect      = 1'b1;
            w_redirect_addr = EXC_VECTOR;
            w_next          = S_FLUSH;
         end
         S_FLUSH: begin
            // Second flush cycle drains anything fetched during FREEZE.
            w_flush = 5'b11110;
            w_next  = w_any_req ? S_STALL : S_RUN;
         end
         default: w_next = S_RUN;
      endcase
      if (rst) begin
         w_stall         = '0;
         w_flush         = '0;
         w_redirect      = 1'b0;
         w_redirect_addr = '0;
         w_next          = S_RUN;
      end
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= w_next;
   end

   // Saturating stall-cycle count, consecutive-stall count and sticky watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cycles <= '0;
         r_consec       <= '0;
         r_timeout      <= 1'b0;
      end else if (w_stall != 5'b00000) begin
         if (r_stall_cycles != {STALL_CNT_W{1'b1}}) r_stall_cycles <= r_stall_cycles + 1'b1;
         if (r_consec != TO_W'(STALL_TIMEOUT))      r_consec       <= r_consec + 1'b1;
         if (r_consec == TO_W'(STALL_TIMEOUT - 1))  r_timeout      <= 1'b1;
      end else begin
         r_consec <= '0;
      end
   end

   assign bus.stall            = w_stall;
   assign bus.flush            = w_flush;
   assign bus.pc_redirect      = w_redirect;
   assign bus.pc_redirect_addr = w_redirect_addr;
   assign bus.ctrl_state       = r_state;
   assign bus.stall_cycles     = r_stall_cycles;
   assign bus.stall_timeout    = r_timeout;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl. Two instances share the same stimulus:
// dut_a uses default parameters, dut_b uses no delay slot, timeout 8, 3-bit counter.
module tb_pipeline_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall_req_id = 1'b0;
   logic        stall_req_ex = 1'b0;
   logic        stall_req_mem = 1'b0;
   logic        branch_flag = 1'b0;
   logic [31:0] branch_addr = '0;
   logic        exception_flag = 1'b0;
   int          n_cmp = 0;
   int          n_mis = 0;

   pipeline_ctrl_if #(.ADDR_W(32), .CNT_W(16)) if_a ();
   pipeline_ctrl_if #(.ADDR_W(32), .CNT_W(3))  if_b ();

   assign if_a.stall_req_id   = stall_req_id;
   assign if_a.stall_req_ex   = stall_req_ex;
   assign if_a.stall_req_mem  = stall_req_mem;
   assign if_a.branch_flag    = branch_flag;
   assign if_a.branch_addr    = branch_addr;
   assign if_a.exception_flag = exception_flag;
   assign if_b.stall_req_id   = stall_req_id;
   assign if_b.stall_req_ex   = stall_req_ex;
   assign if_b.stall_req_mem  = stall_req_mem;
   assign if_b.branch_flag    = branch_flag;
   assign if_b.branch_addr    = branch_addr;
   assign if_b.exception_flag = exception_flag;

   pipeline_ctrl dut_a (.clk(clk), .rst(rst), .bus(if_a));

   pipeline_ctrl #(
      .BRANCH_DELAY_SLOT(1'b0),
      .EXC_VECTOR(32'h0000_0380),
      .STALL_CNT_W(3),
      .STALL_TIMEOUT(8)
   ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   // Advance one active edge and step just past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      stall_req_id = 1'b0; stall_req_ex = 1'b0; stall_req_mem = 1'b0;
      branch_flag = 1'b0; branch_addr = '0; exception_flag = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (if_a.ctrl_state !== 2'b00) begin n_mis++; $display("FAIL reset_state: got %b want 00", if_a.ctrl_state); end
      n_cmp++; if (if_a.stall !== 5'b00000) begin n_mis++; $display("FAIL reset_stall: got %b want 00000", if_a.stall); end
      n_cmp++; if (if_a.flush !== 5'b00000) begin n_mis++; $display("FAIL reset_flush: got %b want 00000", if_a.flush); end
      n_cmp++; if (if_a.pc_redirect !== 1'b0) begin n_mis++; $display("FAIL reset_redirect: got %b want 0", if_a.pc_redirect); end
      n_cmp++; if (if_a.pc_redirect_addr !== 32'h0) begin n_mis++; $display("FAIL reset_addr: got %h want 0", if_a.pc_redirect_addr); end
      n_cmp++; if (if_a.stall_cycles !== 16'd0) begin n_mis++; $display("FAIL reset_cycles: got %0d want 0", if_a.stall_cycles); end
      n_cmp++; if (if_b.stall_timeout !== 1'b0) begin n_mis++; $display("FAIL reset_timeout: got %b want 0", if_b.stall_timeout); end
   endtask

   task automatic test_id_stall();
      do_reset();
      stall_req_id = 1'b1;
      #1;
      n_cmp++; if (if_a.stall !== 5'b00011) begin n_mis++; $display("FAIL id_stall: got %b want 00011", if_a.stall); end
      n_cmp++; if (if_a.flush !== 5'b00100) begin n_mis++; $display("FAIL id_bubble: got %b want 00100", if_a.flush); end
      n_cmp++; if (if_a.ctrl_state !== 2'b00) begin n_mis++; $display("FAIL id_state_run: got %b want 00", if_a.ctrl_state); end
      step();
      stall_req_id = 1'b0;
      #1;
      n_cmp++; if (if_a.ctrl_state !== 2'b01) begin n_mis++; $display("FAIL id_state_stall: got %b want 01", if_a.ctrl_state); end
      n_cmp++; if (if_a.stall !== 5'b00000) begin n_mis++; $display("FAIL id_stall_drop: got %b want 00000", if_a.stall); end
      n_cmp++; if (if_a.stall_cycles !== 16'd1) begin n_mis++; $display("FAIL id_cycles: got %0d want 1", if_a.stall_cycles); end
      step();
      n_cmp++; if (if_a.ctrl_state !== 2'b00) begin n_mis++; $display("FAIL id_state_back: got %b want 00", if_a.ctrl_state); end
      n_cmp++; if (if_a.stall_cycles !== 16'd1) begin n_mis++; $display("FAIL id_cycles_hold: got %0d want 1", if_a.stall_cycles); end
   endtask

   task automatic test_ex_priority();
      do_reset();
      stall_req_id = 1'b1; stall_req_ex = 1'b1;
      #1;
      n_cmp++; if (if_a.stall !== 5'b00111) begin n_mis++; $display("FAIL ex_stall: got %b want 00111", if_a.stall); end
      n_cmp++; if (if_a.flush !== 5'b01000) begin n_mis++; $display("FAIL ex_bubble: got %b want 01000", if_a.flush); end
      step();
      stall_req_ex = 1'b0;
      #1;
      n_cmp++; if (if_a.stall !== 5'b00011) begin n_mis++; $display("FAIL ex_to_id: got %b want 00011", if_a.stall); end
      stall_req_mem = 1'b1;
      #1;
      n_cmp++; if (if_a.stall !== 5'b01111) begin n_mis++; $display("FAIL mem_over_id: got %b want 01111", if_a.stall); end
      stall_req_mem = 1'b0;
      step();
      stall_req_id = 1'b0;
      step();
      n_cmp++; if (if_a.stall_cycles !== 16'd2) begin n_mis++; $display("FAIL ex_cycles: got %0d want 2", if_a.stall_cycles); end
      n_cmp++; if (if_a.ctrl_state !== 2'b00) begin n_mis++; $display("FAIL ex_state: got %b want 00", if_a.ctrl_state); end
   endtask

   task automatic test_branch_under_mem();
      do_reset();
      stall_req_mem = 1'b1; branch_flag = 1'b1; branch_addr = 32'h0000_1000;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++; if (if_a.pc_redirect !== 1'b0) begin n_mis++; $display("FAIL br_deferred[%0d]: got %b want 0", k, if_a.pc_redirect); end
         n_cmp++; if (if_a.flush !== 5'b10000) begin n_mis++; $display("FAIL br_mem_flush[%0d]: got %b want 10000", k, if_a.flush); end
         step();
      end
      stall_req_mem = 1'b0;
      #1;
      n_cmp++; if (if_a.pc_redirect !== 1'b1) begin n_mis++; $display("FAIL br_fire: got %b want 1", if_a.pc_redirect); end
      n_cmp++; if (if_a.pc_redirect_addr !== 32'h0000_1000) begin n_mis++; $display("FAIL br_addr: got %h want 00001000", if_a.pc_redirect_addr); end
      n_cmp++; if (if_a.flush !== 5'b00000) begin n_mis++; $display("FAIL br_slot_flush: got %b want 00000", if_a.flush); end
      n_cmp++; if (if_b.pc_redirect !== 1'b1) begin n_mis++; $display("FAIL br_fire_b: got %b want 1", if_b.pc_redirect); end
      n_cmp++; if (if_b.flush !== 5'b00010) begin n_mis++; $display("FAIL br_noslot_flush: got %b want 00010", if_b.flush); end
      step();
      branch_flag = 1'b0;
      #1;
      n_cmp++; if (if_a.stall_cycles !== 16'd3) begin n_mis++; $display("FAIL br_cycles: got %0d want 3", if_a.stall_cycles); end
      n_cmp++; if (if_a.pc_redirect !== 1'b0) begin n_mis++; $display("FAIL br_done: got %b want 0", if_a.pc_redirect); end
   endtask

   task automatic test_exception();
      do_reset();
      stall_req_id = 1'b1; exception_flag = 1'b1; branch_flag = 1'b1; branch_addr = 32'h0000_2000;
      #1;
      n_cmp++; if (if_a.stall !== 5'b11111) begin n_mis++; $display("FAIL exc_n_stall: got %b want 11111", if_a.stall); end
      n_cmp++; if (if_a.flush !== 5'b00000) begin n_mis++; $display("FAIL exc_n_flush: got %b want 00000", if_a.flush); end
      n_cmp++; if (if_a.pc_redirect !== 1'b0) begin n_mis++; $display("FAIL exc_n_redirect: got %b want 0", if_a.pc_redirect); end
      step();
      stall_req_id = 1'b0; exception_flag = 1'b0; branch_flag = 1'b0;
      #1;
      n_cmp++; if (if_a.ctrl_state !== 2'b10) begin n_mis++; $display("FAIL exc_freeze_state: got %b want 10", if_a.ctrl_state); end
      n_cmp++; if (if_a.stall !== 5'b00000) begin n_mis++; $display("FAIL exc_freeze_stall: got %b want 00000", if_a.stall); end
      n_cmp++; if (if_a.flush !== 5'b11110) begin n_mis++; $display("FAIL exc_freeze_flush: got %b want 11110", if_a.flush); end
      n_cmp++; if (if_a.pc_redirect !== 1'b1) begin n_mis++; $display("FAIL exc_freeze_redirect: got %b want 1", if_a.pc_redirect); end
      n_cmp++; if (if_a.pc_redirect_addr !== 32'h0000_0380) begin n_mis++; $display("FAIL exc_vector: got %h want 00000380", if_a.pc_redirect_addr); end
      step();
      exception_flag = 1'b1;
      #1;
      n_cmp++; if (if_a.ctrl_state !== 2'b11) begin n_mis++; $display("FAIL exc_flush_state: got %b want 11", if_a.ctrl_state); end
      n_cmp++; if (if_a.flush !== 5'b11110) begin n_mis++; $display("FAIL exc_flush_flush: got %b want 11110", if_a.flush); end
      n_cmp++; if (if_a.stall !== 5'b00000) begin n_mis++; $display("FAIL exc_flush_ignore: got %b want 00000", if_a.stall); end
      n_cmp++; if (if_a.pc_redirect !== 1'b0) begin n_mis++; $display("FAIL exc_flush_redirect: got %b want 0", if_a.pc_redirect); end
      step();
      exception_flag = 1'b0;
      #1;
      n_cmp++; if (if_a.ctrl_state !== 2'b00) begin n_mis++; $display("FAIL exc_back_run: got %b want 00", if_a.ctrl_state); end
      n_cmp++; if (if_a.stall_cycles !== 16'd1) begin n_mis++; $display("FAIL exc_cycles: got %0d want 1", if_a.stall_cycles); end
   endtask

   task automatic test_timeout();
      do_reset();
      stall_req_mem = 1'b1;
      repeat (7) step();
      n_cmp++; if (if_b.stall_timeout !== 1'b0) begin n_mis++; $display("FAIL to_early: got %b want 0", if_b.stall_timeout); end
      step();
      n_cmp++; if (if_b.stall_timeout !== 1'b1) begin n_mis++; $display("FAIL to_set: got %b want 1", if_b.stall_timeout); end
      n_cmp++; if (if_a.stall_timeout !== 1'b0) begin n_mis++; $display("FAIL to_default: got %b want 0", if_a.stall_timeout); end
      stall_req_mem = 1'b0;
      step();
      step();
      n_cmp++; if (if_b.stall_timeout !== 1'b1) begin n_mis++; $display("FAIL to_sticky: got %b want 1", if_b.stall_timeout); end
      n_cmp++; if (if_b.ctrl_state !== 2'b00) begin n_mis++; $display("FAIL to_state: got %b want 00", if_b.ctrl_state); end
      do_reset();
      n_cmp++; if (if_b.stall_timeout !== 1'b0) begin n_mis++; $display("FAIL to_cleared: got %b want 0", if_b.stall_timeout); end
   endtask

   task automatic test_saturate_and_reset();
      do_reset();
      stall_req_mem = 1'b1;
      repeat (10) step();
      stall_req_mem = 1'b0;
      #1;
      n_cmp++; if (if_b.stall_cycles !== 3'd7) begin n_mis++; $display("FAIL sat_b: got %0d want 7", if_b.stall_cycles); end
      n_cmp++; if (if_a.stall_cycles !== 16'd10) begin n_mis++; $display("FAIL sat_a: got %0d want 10", if_a.stall_cycles); end
      exception_flag = 1'b1;
      step();
      exception_flag = 1'b0;
      #1;
      n_cmp++; if (if_b.ctrl_state !== 2'b10) begin n_mis++; $display("FAIL rst_pre_freeze: got %b want 10", if_b.ctrl_state); end
      rst = 1'b1;
      #1;
      n_cmp++; if (if_b.pc_redirect !== 1'b0) begin n_mis++; $display("FAIL rst_no_redirect: got %b want 0", if_b.pc_redirect); end
      n_cmp++; if (if_b.flush !== 5'b00000) begin n_mis++; $display("FAIL rst_no_flush: got %b want 00000", if_b.flush); end
      step();
      rst = 1'b0;
      #1;
      n_cmp++; if (if_b.ctrl_state !== 2'b00) begin n_mis++; $display("FAIL rst_state: got %b want 00", if_b.ctrl_state); end
      n_cmp++; if (if_b.pc_redirect !== 1'b0) begin n_mis++; $display("FAIL rst_redirect: got %b want 0", if_b.pc_redirect); end
      n_cmp++; if (if_b.stall_cycles !== 3'd0) begin n_mis++; $display("FAIL rst_cycles: got %0d want 0", if_b.stall_cycles); end
      n_cmp++; if (if_b.stall_timeout !== 1'b0) begin n_mis++; $display("FAIL rst_timeout: got %b want 0", if_b.stall_timeout); end
   endtask

   initial begin
      test_reset();
      test_id_stall();
      test_ex_priority();
      test_branch_under_mem();
      test_exception();
      test_timeout();
      test_saturate_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
